// File: rtl/pr_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between two masters, with a watchdog timeout.
// Latency: a request sampled at cycle N drives s_req at N+1; an ack at N+1 gives done at N+2.
// Backpressure: slave outputs are held until s_ack or timeout; masters hold req until their done pulse.
module pr_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_we,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_we,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_err,
    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_be,
    output logic [DATA_W-1:0] s_wd,
    output logic              s_we,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rd,
    output logic              owner
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              rrLast;
    logic [CNT_W-1:0]  cnt;

    logic              anyReq;
    logic              winner;
    logic [ADDR_W-1:0] winAddr;
    logic [3:0]        winBe;
    logic [DATA_W-1:0] winWd;
    logic              winWe;

    // On a tie the master that did not win last time gets the bus.
    assign anyReq  = m0_req | m1_req;
    assign winner  = (m0_req & m1_req) ? ~rrLast : m1_req;
    assign winAddr = winner ? m1_addr : m0_addr;
    assign winBe   = winner ? m1_be   : m0_be;
    assign winWd   = winner ? m1_wd   : m0_wd;
    assign winWe   = winner ? m1_we   : m0_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rrLast  <= 1'b1;
            cnt     <= '0;
            s_req   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_be    <= '0;
            s_wd    <= '0;
            owner   <= 1'b0;
            m0_done <= 1'b0;
            m0_rd   <= '0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_rd   <= '0;
            m1_err  <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state  <= BUSY;
                        s_req  <= 1'b1;
                        s_addr <= winAddr;
                        s_be   <= winBe;
                        s_wd   <= winWd;
                        s_we   <= winWe;
                        owner  <= winner;
                        rrLast <= winner;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (s_ack) begin
                        if (owner) begin
                            m1_rd   <= s_rd;
                            m1_err  <= 1'b0;
                            m1_done <= 1'b1;
                        end else begin
                            m0_rd   <= s_rd;
                            m0_err  <= 1'b0;
                            m0_done <= 1'b1;
                        end
                        state <= DONE;
                        s_req <= 1'b0;
                        s_we  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        // Slave never answered: complete with an error so the master cannot hang.
                        if (owner) begin
                            m1_rd   <= '0;
                            m1_err  <= 1'b1;
                            m1_done <= 1'b1;
                        end else begin
                            m0_rd   <= '0;
                            m0_err  <= 1'b1;
                            m0_done <= 1'b1;
                        end
                        state <= DONE;
                        s_req <= 1'b0;
                        s_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pr_bus_arbiter.md
Name: pr_bus_arbiter

Overview:
- Shares the single peripheral bus (the Pr address, byte-enable, write-data, write-enable and read-data path) between two masters.
- Master 0 is the CPU MEM stage. Master 1 is a secondary requester, such as a DMA or debug loader.
- Grants one transaction at a time with round-robin fairness, holds the slave-side signals stable until the slave acknowledges, and returns the read data with a one-cycle done pulse.
- A watchdog terminates transactions the slave never acknowledges, so the pipeline cannot hang.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles s_req may stay high without s_ack before forced completion; legal range 1..65535.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 transaction request; held high until m0_done.
- m0_addr  in  ADDR_W  master 0 address.
- m0_be  in  4  master 0 byte enables.
- m0_wd  in  DATA_W  master 0 write data.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_done  out  1  one-cycle completion pulse to master 0.
- m0_rd  out  DATA_W  master 0 read data; valid when m0_done=1.
- m0_err  out  1  master 0 timeout flag; valid with m0_done.
- m1_req, m1_addr, m1_be, m1_wd, m1_we, m1_done, m1_rd, m1_err: same directions, widths and meanings as the m0 ports, for master 1.
- s_req  out  1  slave transaction strobe.
- s_addr  out  ADDR_W  registered slave address.
- s_be  out  4  registered slave byte enables.
- s_wd  out  DATA_W  registered slave write data.
- s_we  out  1  registered slave write enable; only asserted while s_req=1.
- s_ack  in  1  slave completion; may be asserted in the same cycle s_req first rises.
- s_rd  in  DATA_W  slave read data; sampled when s_ack=1.
- owner  out  1  master currently granted; meaningful only while s_req=1.

Behaviour:
- Reset values (asynchronous, reset=0): state=IDLE, s_req=0, s_we=0, s_addr=0, s_be=0, s_wd=0, owner=0, all mX_done=0, mX_rd=0, mX_err=0, rr_last=1 (so master 0 wins the first tie), timeout counter=0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - With no request, remain in IDLE with s_req=0.
  - With exactly one request, grant that master.
  - With both requests, grant the master that is not rr_last.
  - On a grant, register the winner's addr/be/wd/we into the s_* outputs, set owner, set rr_last to the winner, clear the counter and go to BUSY.
- BUSY:
  - s_req=1; s_* outputs are held stable, and master inputs are not re-sampled.
  - If s_ack=1: capture s_rd into the owner's mX_rd (writes also capture s_rd, which masters ignore), set mX_err=0, go to DONE.
  - Else if counter==TIMEOUT-1: set the owner's mX_rd=0 and mX_err=1, go to DONE.
  - Otherwise increment the counter.
- DONE:
  - s_req=0, s_we=0; the owner's mX_done=1 for exactly this cycle; go to IDLE.
  - Requests are not evaluated in DONE. The completed master drops req this cycle, which prevents a stale re-grant.
- Latency: req sampled at cycle N, s_req high at N+1. Ack at N+1 gives done at N+2; the next grant is sampled at N+3.
- mX_rd and mX_err hold their values until that master's next completion.
- The non-owner's done/rd/err never change.
- Request deassertion while BUSY is ignored; the transaction completes anyway.
- s_ack while in IDLE or DONE is ignored.
- Reset asserted mid-transaction aborts immediately to the reset values with no done pulse.
- Fairness: with both masters continuously requesting, grants strictly alternate, so neither master waits more than one transaction.
- Counter width is clog2(TIMEOUT)+1 bits and never wraps.

Test Plan:
1. Single read: m0_req=1, m0_addr=0x7F00, m0_we=0; slave acks on s_req's first cycle with s_rd=0x12345678 -> s_req high 1 cycle, m0_done pulses 2 cycles after req, m0_rd=0x12345678, m0_err=0.
2. Simultaneous requests from reset: m0 and m1 both request continuously, slave acks after 3 cycles each time -> grant order m0,m1,m0,m1; s_addr/s_wd stable while s_req=1; each done is a single pulse.
3. Write with stalled slave: m1_we=1, m1_wd=0xCAFEBABE, m1_be=4'b0011, s_ack delayed 10 cycles while m1_req drops after 2 cycles -> s_we/s_wd/s_be held all 10 cycles, m1_done pulses once, m1_err=0.
4. Timeout: TIMEOUT=4, m0 read, s_ack never asserted -> s_req high exactly 4 cycles, then m0_done=1 with m0_err=1 and m0_rd=0; arbiter then returns to IDLE and serves a pending m1 request.
5. Reset mid-operation: pull reset low during BUSY -> s_req=0 and all outputs zero asynchronously with no done pulse; after release, a simultaneous request is granted to m0 first.
6. Spurious ack: s_ack=1 while IDLE with no requests -> no done pulses, m0_rd and m1_rd unchanged.
